bus_cycle_decoder: RTL and testbench
====================================

// Module: bus_cycle_decoder
// PURPOSE
// Front end of the 8088 bus: demultiplexes AD[7:0]/A[19:8] into a stable 20-bit address, decodes
// IO/M and address into four active-low chip selects (one per memory/IO device), and drives READY
// to insert per-region wait states. Sits between the 8088 pins and the memory/IO device FSMs;
// each device samples its CS_n together with ALE, so CS_n must already be valid in the ALE cycle.
// PARAMETERS
// MEM_SPLIT  20'h80000  memory addr < MEM_SPLIT -> region 0, >= MEM_SPLIT -> region 1
// IO0_PAGE   8'h1C      IO cycle with addr[15:8]==IO0_PAGE -> region 2
// IO1_PAGE   8'hFF      IO cycle with addr[15:8]==IO1_PAGE -> region 3
// WS0..WS3   0,0,1,3    wait states for regions 0..3 (range 0..15, 4-bit)
// PORTS
// CLK        in   1   bus clock
// RESET      in   1   asynchronous, active-high reset
// ALE        in   1   address latch enable from CPU (high for one T1 cycle)
// IOM        in   1   1 = IO cycle, 0 = memory cycle; valid while ALE high
// AD         in   8   multiplexed address/data low byte (address part used only)
// A          in   12  address bits 19:8
// RD_n       in   1   active-low read strobe
// WR_n       in   1   active-low write strobe
// Address    out  20  latched bus address
// CS_n       out  4   active-low chip selects, bit k = region k
// READY      out  1   1 = device ready; 0 = insert wait state
// unmapped   out  1   one-cycle pulse: ALE cycle decoded to no region
// proto_err  out  1   one-cycle pulse: RD_n and WR_n both low
// BEHAVIOUR
// - Async reset: state IDLE, Address=0, CS_n=4'hF, READY=1, unmapped=0, proto_err=0, counter=0.
// - decode(addr,iom): iom=0 -> region 0/1 via MEM_SPLIT; iom=1 -> region 2/3 via addr[15:8]
//   match (region 2 wins if both pages equal); no match -> none.
// - CS_n combinational: while ALE=1, decode of live {A,AD},IOM; otherwise decode of latched
//   Address/IOM gated by state != IDLE. Never more than one bit low.
// - FSM states IDLE, ADDR, WAIT, XFER:
//   IDLE: ALE=1 -> latch Address<={A,AD}, iom_q<=IOM, cnt<=WS[region]; go ADDR
//     (unmapped: pulse unmapped, latch anyway, stay IDLE so CS_n stays high).
//   ADDR: !RD_n or !WR_n -> WAIT if cnt!=0 else XFER; otherwise hold.
//   WAIT: READY=0 (registered, low from first WAIT cycle); cnt<=cnt-1; cnt==1 -> XFER.
//   XFER: READY=1; RD_n & WR_n both high -> IDLE (CS_n deasserts next cycle).
// - Wait count N gives exactly N cycles with READY=0, starting the cycle after strobe seen.
// - ALE=1 in any non-IDLE state: abort current cycle, re-latch, restart as from IDLE; READY=1.
// - RD_n and WR_n both low: pulse proto_err; treated as read for state progression.
// - Address holds between ALE pulses; changes only on ALE-sampling edge.
// - RESET mid-cycle: immediate return to reset values, CS_n high asynchronously.
// TESTING
// - Mem read 0x12345 (WS0=0): ALE+IOM=0 -> CS_n=4'b1110 during ALE, Address=0x12345, READY
//   never low, CS_n=4'hF one cycle after RD_n rises.
// - Mem write 0xA0000: CS_n=4'b1101 from ALE cycle through WR_n rise; READY stays 1.
// - IO read port 0xFF10 (WS3=3): CS_n=4'b0111; READY low exactly 3 cycles after RD_n falls, then 1.
// - IO port 0x5000: unmapped pulses 1 cycle, CS_n stays 4'hF, READY stays 1, FSM stays IDLE.
// - Region 2 read with WS2=1, new ALE during WAIT: READY returns 1, Address re-latched,
//   CS_n follows the new decode.
// - RESET asserted during WAIT of region 3: CS_n=4'hF and READY=1 same cycle, Address=0.

Source files
------------

// File: rtl/bus_cycle_decoder.sv
// 8088 bus front end. It latches the multiplexed address, decodes four
// active-low chip selects, and holds READY low for each region's wait states.
// A device samples CS_n together with ALE, so in the ALE cycle CS_n comes
// straight from the live pins.
module bus_cycle_decoder #(
    parameter logic [19:0] MEM_SPLIT = 20'h80000,
    parameter logic [7:0]  IO0_PAGE  = 8'h1C,
    parameter logic [7:0]  IO1_PAGE  = 8'hFF,
    parameter logic [3:0]  WS0       = 4'd0,
    parameter logic [3:0]  WS1       = 4'd0,
    parameter logic [3:0]  WS2       = 4'd1,
    parameter logic [3:0]  WS3       = 4'd3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ALE,
    input  logic        IOM,
    input  logic [7:0]  AD,
    input  logic [11:0] A,
    input  logic        RD_n,
    input  logic        WR_n,
    output logic [19:0] Address,
    output logic [3:0]  CS_n,
    output logic        READY,
    output logic        unmapped,
    output logic        proto_err,
    output logic [1:0]  dbg_state_o
);

    // Bus cycle phases. ADDR waits for a strobe. WAIT holds READY low.
    // XFER waits for both strobes to go high again.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2,
        S_XFER = 2'd3
    } state_t;

    state_t      state_q;
    logic [19:0] addr_q;
    logic        iom_q;
    logic [3:0]  cnt_q;
    logic        ready_q;
    logic        unmapped_q;
    logic        proto_err_q;

    logic [19:0] live_addr;
    logic [2:0]  live_dec;
    logic [2:0]  lat_dec;
    logic        strobe;
    logic [3:0]  cs_n_c;

    // Decode result is {hit, region[1:0]}. The IO0 page takes priority over the IO1 page.
    function automatic logic [2:0] decode(input logic [19:0] addr, input logic iom);
        logic [2:0] res;
        res = 3'b000;
        if (!iom) begin
            res = (addr < MEM_SPLIT) ? 3'b100 : 3'b101;
        end else if (addr[15:8] == IO0_PAGE) begin
            res = 3'b110;
        end else if (addr[15:8] == IO1_PAGE) begin
            res = 3'b111;
        end
        return res;
    endfunction

    function automatic logic [3:0] ws_of(input logic [1:0] region);
        logic [3:0] ws;
        case (region)
            2'd0:    ws = WS0;
            2'd1:    ws = WS1;
            2'd2:    ws = WS2;
            default: ws = WS3;
        endcase
        return ws;
    endfunction

    assign live_addr = {A, AD};
    assign live_dec  = decode(live_addr, IOM);
    assign lat_dec   = decode(addr_q, iom_q);
    assign strobe    = !RD_n || !WR_n;

    // Chip select: decode the live pins during ALE, otherwise the latched cycle; forced high in reset
    always_comb begin
        cs_n_c = 4'hF;
        if (RESET) begin
            cs_n_c = 4'hF;
        end else if (ALE) begin
            if (live_dec[2]) cs_n_c[live_dec[1:0]] = 1'b0;
        end else if (state_q != S_IDLE) begin
            if (lat_dec[2]) cs_n_c[lat_dec[1:0]] = 1'b0;
        end
    end

    // Bus cycle FSM with registered READY and status pulses. ALE always restarts the cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            addr_q      <= 20'h0;
            iom_q       <= 1'b0;
            cnt_q       <= 4'd0;
            ready_q     <= 1'b1;
            unmapped_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= !RD_n && !WR_n;
            unmapped_q  <= 1'b0;
            if (ALE) begin
                addr_q  <= live_addr;
                iom_q   <= IOM;
                ready_q <= 1'b1;
                if (live_dec[2]) begin
                    cnt_q   <= ws_of(live_dec[1:0]);
                    state_q <= S_ADDR;
                end else begin
                    cnt_q      <= 4'd0;
                    unmapped_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
            end else begin
                case (state_q)
                    S_ADDR: begin
                        if (strobe) begin
                            if (cnt_q != 4'd0) begin
                                state_q <= S_WAIT;
                                ready_q <= 1'b0;
                            end else begin
                                state_q <= S_XFER;
                                ready_q <= 1'b1;
                            end
                        end
                    end
                    S_WAIT: begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q <= 4'd1) begin
                            state_q <= S_XFER;
                            ready_q <= 1'b1;
                        end
                    end
                    S_XFER: begin
                        ready_q <= 1'b1;
                        if (RD_n && WR_n) state_q <= S_IDLE;
                    end
                    default: begin
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign Address     = addr_q;
    assign CS_n        = cs_n_c;
    assign READY       = ready_q;
    assign unmapped    = unmapped_q;
    assign proto_err   = proto_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_cycle_decoder.sv
// Bench for bus_cycle_decoder: directed vector table, randomized bus cycles
// checked against a region/wait-state model, and hand-built corner sequences.
module tb_bus_cycle_decoder;

  logic        clk;
  logic        rst;
  logic        ale;
  logic        iom;
  logic [7:0]  ad;
  logic [11:0] a;
  logic        rd_n;
  logic        wr_n;
  logic [19:0] address;
  logic [3:0]  cs_n;
  logic        ready;
  logic        unmapped;
  logic        proto_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [19:0] prev_addr = 20'h0;

  bus_cycle_decoder dut (
    .CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .AD(ad), .A(a),
    .RD_n(rd_n), .WR_n(wr_n), .Address(address), .CS_n(cs_n), .READY(ready),
    .unmapped(unmapped), .proto_err(proto_err), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] addr;
    logic        iom;
    logic        wr;
    logic [3:0]  exp_cs;
    int          exp_ws;
    logic        exp_unm;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: region from the address map, -1 when nothing matches
  function automatic int ref_region(input logic [19:0] addr, input logic io);
    if (!io) return (addr < 20'h80000) ? 0 : 1;
    if (addr[15:8] == 8'h1C) return 2;
    if (addr[15:8] == 8'hFF) return 3;
    return -1;
  endfunction

  function automatic int ref_ws(input int region);
    int ws_tab[4] = '{0, 0, 1, 3};
    return ws_tab[region];
  endfunction

  // Advance to the next cycle; inputs are driven 1ns after the rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Run one full 8088 bus cycle: ALE, strobe held for the wait states plus slack, then release
  task automatic run_txn(input string name, input logic [19:0] addr, input logic io,
                         input logic wr, input logic [3:0] exp_cs, input int exp_ws,
                         input logic exp_unm);
    int extra;
    int len;
    int low_cnt;
    logic [3:0] e_cs;
    logic e_rdy;
    extra = $urandom_range(0, 2);
    len = exp_ws + 1 + extra;
    low_cnt = 0;
    for (int c = 0; c <= len + 2; c++) begin
      next_cycle();
      ale = (c == 0);
      if (c == 0) begin
        a = addr[19:8]; ad = addr[7:0]; iom = io;
      end else begin
        a = 12'($urandom); ad = 8'($urandom); iom = 1'($urandom);
      end
      rd_n = !((c >= 1) && (c <= len) && !wr);
      wr_n = !((c >= 1) && (c <= len) && wr);
      @(negedge clk);
      e_cs  = (exp_unm || c > len + 1) ? 4'hF : exp_cs;
      e_rdy = exp_unm ? 1'b1 : !((c >= 2) && (c <= exp_ws + 1));
      chk($sformatf("%s cs_n c%0d", name, c), 32'(cs_n), 32'(e_cs));
      chk($sformatf("%s ready c%0d", name, c), 32'(ready), 32'(e_rdy));
      chk($sformatf("%s addr c%0d", name, c), 32'(address), 32'((c == 0) ? prev_addr : addr));
      chk($sformatf("%s unmapped c%0d", name, c), 32'(unmapped), 32'(exp_unm && c == 1));
      chk($sformatf("%s proto_err c%0d", name, c), 32'(proto_err), 32'h0);
      if (!ready) low_cnt++;
    end
    chk($sformatf("%s wait count", name), 32'(low_cnt), 32'(exp_unm ? 0 : exp_ws));
    prev_addr = addr;
  endtask

  initial begin
    int reg_n;
    logic [19:0] r_addr;
    logic r_io;
    logic [3:0] r_cs;

    rst = 1'b1; ale = 1'b0; iom = 1'b0; ad = 8'h0; a = 12'h0; rd_n = 1'b1; wr_n = 1'b1;
    #12;
    chk("reset cs_n", 32'(cs_n), 32'hF);
    chk("reset ready", 32'(ready), 32'h1);
    chk("reset addr", 32'(address), 32'h0);
    chk("reset unmapped", 32'(unmapped), 32'h0);
    chk("reset proto_err", 32'(proto_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    vecs.push_back('{20'h12345, 1'b0, 1'b0, 4'b1110, 0, 1'b0});
    vecs.push_back('{20'hA0000, 1'b0, 1'b1, 4'b1101, 0, 1'b0});
    vecs.push_back('{20'h0FF10, 1'b1, 1'b0, 4'b0111, 3, 1'b0});
    vecs.push_back('{20'h05000, 1'b1, 1'b0, 4'b1111, 0, 1'b1});
    vecs.push_back('{20'h01C00, 1'b1, 1'b1, 4'b1011, 1, 1'b0});
    vecs.push_back('{20'h7FFFF, 1'b0, 1'b0, 4'b1110, 0, 1'b0});
    vecs.push_back('{20'h80000, 1'b0, 1'b1, 4'b1101, 0, 1'b0});
    vecs.push_back('{20'h3FF00, 1'b1, 1'b0, 4'b0111, 3, 1'b0});
    vecs.push_back('{20'h11D00, 1'b1, 1'b0, 4'b1111, 0, 1'b1});
    vecs.push_back('{20'hFFFFF, 1'b0, 1'b0, 4'b1101, 0, 1'b0});
    foreach (vecs[i])
      run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].iom, vecs[i].wr,
              vecs[i].exp_cs, vecs[i].exp_ws, vecs[i].exp_unm);

    // Randomized cycles against the reference model
    for (int i = 0; i < 40; i++) begin
      r_addr = 20'($urandom);
      r_io = 1'($urandom);
      case ($urandom_range(0, 2))
        0: r_addr[15:8] = 8'h1C;
        1: r_addr[15:8] = 8'hFF;
        default: ;
      endcase
      reg_n = ref_region(r_addr, r_io);
      r_cs = (reg_n < 0) ? 4'hF : ~(4'b0001 << reg_n);
      run_txn($sformatf("rnd%0d", i), r_addr, r_io, 1'($urandom), r_cs,
              (reg_n < 0) ? 0 : ref_ws(reg_n), reg_n < 0);
    end

    // New ALE during the WAIT of a region 2 read
    next_cycle(); ale = 1'b1; a = 12'h01C; ad = 8'h05; iom = 1'b1;
    @(negedge clk); chk("abort cs ale1", 32'(cs_n), 32'hB);
    next_cycle(); ale = 1'b0; rd_n = 1'b0;
    @(negedge clk); chk("abort addr1", 32'(address), 32'h01C05);
    next_cycle(); ale = 1'b1; rd_n = 1'b1; a = 12'h001; ad = 8'h00; iom = 1'b0;
    @(negedge clk);
    chk("abort ready in wait", 32'(ready), 32'h0);
    chk("abort cs live", 32'(cs_n), 32'hE);
    next_cycle(); ale = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    chk("abort ready back", 32'(ready), 32'h1);
    chk("abort addr2", 32'(address), 32'h00100);
    chk("abort cs new", 32'(cs_n), 32'hE);
    next_cycle(); rd_n = 1'b1;
    @(negedge clk);
    chk("abort xfer ready", 32'(ready), 32'h1);
    chk("abort xfer cs", 32'(cs_n), 32'hE);
    next_cycle();
    @(negedge clk); chk("abort end cs", 32'(cs_n), 32'hF);

    // RD_n and WR_n low together
    next_cycle(); ale = 1'b1; a = 12'h000; ad = 8'h10; iom = 1'b0;
    next_cycle(); ale = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    next_cycle(); rd_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    chk("proto_err pulse", 32'(proto_err), 32'h1);
    chk("proto cs", 32'(cs_n), 32'hE);
    chk("proto ready", 32'(ready), 32'h1);
    next_cycle();
    @(negedge clk);
    chk("proto_err clear", 32'(proto_err), 32'h0);
    chk("proto end cs", 32'(cs_n), 32'hF);

    // Reset during the WAIT of a region 3 read
    next_cycle(); ale = 1'b1; a = 12'h0FF; ad = 8'h10; iom = 1'b1;
    next_cycle(); ale = 1'b0; rd_n = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("rst pre ready", 32'(ready), 32'h0);
    chk("rst pre cs", 32'(cs_n), 32'h7);
    #1 rst = 1'b1;
    #1;
    chk("rst mid cs", 32'(cs_n), 32'hF);
    chk("rst mid ready", 32'(ready), 32'h1);
    chk("rst mid addr", 32'(address), 32'h0);
    @(negedge clk);
    rst = 1'b0; rd_n = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rst post cs", 32'(cs_n), 32'hF);
    chk("rst post ready", 32'(ready), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
